// File: rtl/prio_enc_pipe_if.sv
// prio_enc_pipe_if: sample-in / result-out handshake bundle for prio_enc_pipe.
interface prio_enc_pipe_if #(
   parameter int CODE_W = 2,
   parameter int CNT_W  = 16
);
   logic              in_valid, in_ready, out_valid, out_ready, out_none;
   logic [CODE_W-1:0] ch0, ch1, ch2, ch3;
   logic [1:0]        out_index;
   logic [CNT_W-1:0]  match_count;
   modport master (
      output in_valid, ch0, ch1, ch2, ch3, out_ready,
      input  in_ready, out_valid, out_index, out_none, match_count
   );
   modport slave (
      input  in_valid, ch0, ch1, ch2, ch3, out_ready,
      output in_ready, out_valid, out_index, out_none, match_count
   );
endinterface

// File: rtl/prio_enc_pipe.sv
// prio_enc_pipe: two-stage handshaked priority encoder with saturating match counter.
// Define ROUND_ROBIN_EN to rotate priority so the last winner drops to lowest priority.
module prio_enc_pipe #(
   parameter int         CODE_W     = 2,
   parameter int         MATCH_VAL  = 1,
   parameter logic [1:0] NONE_INDEX = 2'd0,
   parameter int         CNT_W      = 16
) (
   input logic            clk_in,
   input logic            rst_n_in,
   prio_enc_pipe_if.slave bus
);
   logic             adv2, load2, found;
   logic             s1_valid_d, s1_valid_q;
   logic [3:0]       match_d, match_q;
   logic             out_valid_d, out_valid_q;
   logic [1:0]       out_index_d, out_index_q;
   logic             out_none_d, out_none_q;
   logic [CNT_W-1:0] match_count_d, match_count_q;
   logic [1:0]       base, idx, win;
`ifdef ROUND_ROBIN_EN
   logic [1:0]       ptr_d, ptr_q;
   assign base  = ptr_q;
   assign ptr_d = (load2 && found) ? win : ptr_q;
`else
   assign base = 2'd0;
`endif
   assign adv2            = !out_valid_q || bus.out_ready;
   assign load2           = adv2 && s1_valid_q;
   assign bus.in_ready    = !s1_valid_q || adv2;
   assign bus.out_valid   = out_valid_q;
   assign bus.out_index   = out_index_q;
   assign bus.out_none    = out_none_q;
   assign bus.match_count = match_count_q;
   always_comb begin
      s1_valid_d = bus.in_ready ? bus.in_valid : s1_valid_q;
      match_d    = (bus.in_ready && bus.in_valid) ?
                   {bus.ch3 == CODE_W'(MATCH_VAL), bus.ch2 == CODE_W'(MATCH_VAL),
                    bus.ch1 == CODE_W'(MATCH_VAL), bus.ch0 == CODE_W'(MATCH_VAL)} : match_q;
      found = 1'b0;
      win   = NONE_INDEX;
      idx   = base;
      // search base-1, base-2, base-3, base; base=0 gives 3,2,1,0
      for (int o = 1; o <= 4; o++) begin
         idx = base - 2'(o);
         if (!found && match_q[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
      out_valid_d   = adv2 ? s1_valid_q : out_valid_q;
      out_index_d   = load2 ? win : out_index_q;
      out_none_d    = load2 ? !found : out_none_q;
      match_count_d = (out_valid_q && bus.out_ready && !out_none_q && match_count_q != '1) ?
                      match_count_q + CNT_W'(1) : match_count_q;
   end
   always_ff @(posedge clk_in) begin
      if (!rst_n_in) begin
         s1_valid_q    <= 1'b0;
         match_q       <= '0;
         out_valid_q   <= 1'b0;
         out_index_q   <= 2'd0;
         out_none_q    <= 1'b0;
         match_count_q <= '0;
`ifdef ROUND_ROBIN_EN
         ptr_q         <= 2'd0;
`endif
      end else begin
         s1_valid_q    <= s1_valid_d;
         match_q       <= match_d;
         out_valid_q   <= out_valid_d;
         out_index_q   <= out_index_d;
         out_none_q    <= out_none_d;
         match_count_q <= match_count_d;
`ifdef ROUND_ROBIN_EN
         ptr_q         <= ptr_d;
`endif
      end
   end
endmodule

// File: tb/tb_prio_enc_pipe.sv
// tb_prio_enc_pipe: directed checks of latency, encoding, stall, reset, saturation and priority order.
module tb_prio_enc_pipe;
   logic clk_in = 1'b0;
   logic rst_n_in = 1'b0;
   int   checks = 0;
   int   failures = 0;
   logic [2:0] got_q[$];
   always #5 clk_in = ~clk_in;
   prio_enc_pipe_if #(.CODE_W(2), .CNT_W(16)) bus ();
   prio_enc_pipe_if #(.CODE_W(2), .CNT_W(3))  bus_s ();
   prio_enc_pipe #(.CNT_W(16)) dut (.clk_in(clk_in), .rst_n_in(rst_n_in), .bus(bus));
   prio_enc_pipe #(.CNT_W(3))  dut_s (.clk_in(clk_in), .rst_n_in(rst_n_in), .bus(bus_s));
   // {out_none, out_index} of every accepted output of the main DUT
   always @(negedge clk_in)
      if (rst_n_in && bus.out_valid && bus.out_ready) got_q.push_back({bus.out_none, bus.out_index});
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk_in);
         #1;
      end
   endtask
   task automatic set_ch(input logic [1:0] c3, c2, c1, c0);
      bus.ch3 = c3;
      bus.ch2 = c2;
      bus.ch1 = c1;
      bus.ch0 = c0;
   endtask
   task automatic send(input logic [1:0] c3, c2, c1, c0);
      int   n = 0;
      logic rdy = 1'b0;
      set_ch(c3, c2, c1, c0);
      bus.in_valid = 1'b1;
      while (!rdy && n < 50) begin
         @(negedge clk_in);
         rdy = bus.in_ready;
         tick(1);
         n++;
      end
      chk("send_accepted", rdy, 1);
      bus.in_valid = 1'b0;
   endtask
   task automatic expect_q(input string tag, input logic [2:0] exp);
      int          n = 0;
      logic [31:0] v = 'x;
      while (got_q.size() == 0 && n < 50) begin
         @(negedge clk_in);
         n++;
      end
      if (got_q.size() != 0) v = 32'(got_q.pop_front());
      chk(tag, v, 32'(exp));
   endtask
   task automatic do_reset();
      rst_n_in = 1'b0;
      tick(1);
      rst_n_in = 1'b1;
   endtask
   initial begin
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      set_ch(0, 0, 0, 0);
      bus_s.in_valid = 1'b0;
      bus_s.out_ready = 1'b1;
      {bus_s.ch3, bus_s.ch2, bus_s.ch1, bus_s.ch0} = '0;
      // reset held 3 cycles
      tick(3);
      rst_n_in = 1'b1;
      @(negedge clk_in);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_count", bus.match_count, 0);
      chk("rst_in_ready", bus.in_ready, 1);
      chk("rst_out_index", bus.out_index, 0);
      chk("rst_out_none", bus.out_none, 0);
      // latency: ch3=2 ch2=1 ch1=1 ch0=0 -> index 2 two cycles later
      tick(1);
      set_ch(2, 1, 1, 0);
      bus.in_valid = 1'b1;
      tick(1);
      bus.in_valid = 1'b0;
      @(negedge clk_in);
      chk("lat_c1_valid", bus.out_valid, 0);
      tick(1);
      @(negedge clk_in);
      chk("lat_c2_valid", bus.out_valid, 1);
      chk("lat_index", bus.out_index, 2);
      chk("lat_none", bus.out_none, 0);
      tick(1);
      @(negedge clk_in);
      chk("lat_count", bus.match_count, 1);
      chk("lat_drained", bus.out_valid, 0);
      // no match
      tick(1);
      set_ch(0, 0, 0, 0);
      bus.in_valid = 1'b1;
      tick(1);
      bus.in_valid = 1'b0;
      tick(1);
      @(negedge clk_in);
      chk("none_valid", bus.out_valid, 1);
      chk("none_flag", bus.out_none, 1);
      chk("none_index", bus.out_index, 0);
      tick(1);
      @(negedge clk_in);
      chk("none_count", bus.match_count, 1);
      // stall: samples with winners 3,1,0 offered while out_ready=0
      tick(1);
      got_q.delete();
      bus.out_ready = 1'b0;
      set_ch(1, 0, 0, 0);
      bus.in_valid = 1'b1;
      tick(1);
      set_ch(0, 0, 1, 0);
      tick(1);
      set_ch(0, 0, 0, 1);
      repeat (3) begin
         @(negedge clk_in);
         chk("stall_in_ready", bus.in_ready, 0);
         chk("stall_valid", bus.out_valid, 1);
         chk("stall_hold_index", bus.out_index, 3);
         tick(1);
      end
      bus.out_ready = 1'b1;
      tick(1);
      bus.in_valid = 1'b0;
      expect_q("stall_order0", 3'd3);
      expect_q("stall_order1", 3'd1);
      expect_q("stall_order2", 3'd0);
      tick(3);
      chk("stall_no_dup", got_q.size(), 0);
      chk("stall_count", bus.match_count, 4);
      // reset with a sample in flight
      set_ch(1, 1, 1, 1);
      bus.in_valid = 1'b1;
      tick(1);
      bus.in_valid = 1'b0;
      got_q.delete();
      do_reset();
      tick(3);
      @(negedge clk_in);
      chk("midrst_no_output", got_q.size(), 0);
      chk("midrst_valid", bus.out_valid, 0);
      chk("midrst_count", bus.match_count, 0);
      // back-to-back patterns, pointer starts at 0
      tick(1);
      got_q.delete();
      send(0, 0, 0, 1);
      send(0, 1, 0, 1);
      send(0, 0, 1, 3);
      send(1, 1, 1, 1);
      send(3, 2, 0, 0);
      expect_q("str_ch0", 3'd0);
      expect_q("str_ch2", 3'd2);
      expect_q("str_ch1", 3'd1);
`ifdef ROUND_ROBIN_EN
      expect_q("str_all", 3'd0);
`else
      expect_q("str_all", 3'd3);
`endif
      expect_q("str_none", 3'b100);
      tick(2);
      chk("str_count", bus.match_count, 4);
      // ch1=ch2=1 three times from a fresh pointer
      do_reset();
      got_q.delete();
      send(0, 1, 1, 0);
      send(0, 1, 1, 0);
      send(0, 1, 1, 0);
      expect_q("pri_0", 3'd2);
`ifdef ROUND_ROBIN_EN
      expect_q("pri_1", 3'd1);
`else
      expect_q("pri_1", 3'd2);
`endif
      expect_q("pri_2", 3'd2);
      // 3-bit counter saturates at 7 after 9 matches
      chk("sat_start", bus_s.match_count, 0);
      bus_s.ch0 = 2'd1;
      bus_s.in_valid = 1'b1;
      tick(9);
      bus_s.in_valid = 1'b0;
      tick(4);
      @(negedge clk_in);
      chk("sat_count", bus_s.match_count, 7);
      chk("sat_index", bus_s.out_index, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
